// File: rtl/muldiv_ctrl_if.sv
// Execute-side bundle for the mul/div sequencer.
// Carries requests, cancel, MT writes, MF hazard and HI/LO.
interface muldiv_ctrl_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        req_ready;
  logic        cancel;
  logic        mthi_en;
  logic        mtlo_en;
  logic [31:0] mt_data;
  logic        mf_req;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        stall_out;

  modport master (
    output req_valid, req_op, src_a, src_b,
    output cancel, mthi_en, mtlo_en, mt_data, mf_req,
    input  req_ready, hi_out, lo_out, busy, done, stall_out
  );

  modport slave (
    input  req_valid, req_op, src_a, src_b,
    input  cancel, mthi_en, mtlo_en, mt_data, mf_req,
    output req_ready, hi_out, lo_out, busy, done, stall_out
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Registered multiplier plus radix-2 restoring divider.
module muldiv_ctrl #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_ITERS = 32
) (
  input logic         clk,
  input logic         resetn,
  muldiv_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, MUL, DIV, FIN
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] babs_q, babs_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        sgn;
  logic [63:0] ma, mb, mprod;
  logic [32:0] sh;
  logic        ge;
  logic [31:0] diff;
  logic [31:0] qfix, rfix;

  // Signed ops sign-extend; the low 64 bits cover both signednesses.
  assign sgn   = ~op_q[0];
  assign ma    = {{32{sgn & a_q[31]}}, a_q};
  assign mb    = {{32{sgn & b_q[31]}}, b_q};
  assign mprod = ma * mb;

  // One restoring step on the shifted {rem,quo} pair.
  assign sh   = {rem_q, quo_q[31]};
  assign ge   = sh >= {1'b0, babs_q};
  assign diff = sh[31:0] - babs_q;
  assign qfix = (sa_q ^ sb_q) ? -quo_q : quo_q;
  assign rfix = sa_q ? -rem_q : rem_q;

  // Next-state, datapath and HI/LO update selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    babs_d  = babs_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mthi_en) hi_d = bus.mt_data;
        if (bus.mtlo_en) lo_d = bus.mt_data;
        if (bus.req_valid && !bus.cancel) begin
          op_d   = bus.req_op;
          a_d    = bus.src_a;
          b_d    = bus.src_b;
          sa_d   = ~bus.req_op[0] & bus.src_a[31];
          sb_d   = ~bus.req_op[0] & bus.src_b[31];
          quo_d  = sa_d ? -bus.src_a : bus.src_a;
          babs_d = sb_d ? -bus.src_b : bus.src_b;
          rem_d  = '0;
          if (bus.req_op[1]) begin
            state_d = DIV;
            cnt_d   = 6'(DIV_ITERS);
          end else begin
            state_d = MUL;
            cnt_d   = 6'(MUL_LAT);
          end
        end
      end
      MUL: begin
        prod_d = mprod;
        if (cnt_q == 6'd1) state_d = FIN;
        else cnt_d = cnt_q - 6'd1;
      end
      DIV: begin
        rem_d = ge ? diff : sh[31:0];
        quo_d = {quo_q[30:0], ge};
        if (cnt_q == 6'd1) state_d = FIN;
        else cnt_d = cnt_q - 6'd1;
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          hi_d = prod_q[63:32];
          lo_d = prod_q[31:0];
        end else if (babs_q == '0) begin
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rfix;
          lo_d = qfix;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.cancel && state_q != IDLE) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      babs_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      babs_q  <= babs_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.req_ready = (state_q == IDLE);
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
  assign bus.done      = done_q;
  assign bus.stall_out = bus.busy &
    (bus.req_valid | bus.mf_req | bus.mthi_en | bus.mtlo_en);
endmodule
